// File: rtl/data_memory_pkg.sv
// data_memory_pkg -- shared types and helpers for the data_memory block.
// Holds the RISC-V funct3 access codes, the clear/ready state encoding and
// the small pure functions that turn an access code plus byte lane into
// byte enables, store data and the misalignment flag.
package data_memory_pkg;

    // Load codes (funct3). Stores reuse the same codes for SB/SH/SW.
    typedef enum logic [2:0] {
        LB  = 3'b000,
        LH  = 3'b001,
        LW  = 3'b010,
        LBU = 3'b100,
        LHU = 3'b101
    } dmctrl_e;

    // Store aliases: an enum cannot repeat a value, so they are named
    // constants of the same type.
    localparam dmctrl_e SB = LB;
    localparam dmctrl_e SH = LH;
    localparam dmctrl_e SW = LW;

    // CLEAR zeroes the array one word per cycle; READY serves accesses.
    typedef enum logic {
        CLEAR = 1'b0,
        READY = 1'b1
    } dm_state_e;

    // Byte-lane write enables for a store. Halfwords pick the pair with
    // lane[1] and words take all four lanes, so low address bits that do
    // not matter for the size are ignored (forced alignment).
    function automatic logic [3:0] store_byte_en(input logic [2:0] ctrl,
                                                 input logic [1:0] lane);
        logic [3:0] be;
        be = 4'b0000;
        case (ctrl)
            SB:      be = 4'b0001 << lane;
            SH:      be = lane[1] ? 4'b1100 : 4'b0011;
            SW:      be = 4'b1111;
            default: be = 4'b0000;
        endcase
        return be;
    endfunction

    // Store data replicated across lanes so the byte enables alone decide
    // which bytes land in the word.
    function automatic logic [31:0] store_data(input logic [2:0] ctrl,
                                               input logic [31:0] data);
        logic [31:0] d;
        case (ctrl)
            SB:      d = {4{data[7:0]}};
            SH:      d = {2{data[15:0]}};
            default: d = data;
        endcase
        return d;
    endfunction

    // Natural-alignment check: halfwords need lane[0]=0, words lane=00.
    // The LHU code is included so a halfword load flags like LH does.
    function automatic logic access_misaligned(input logic [2:0] ctrl,
                                               input logic [1:0] lane);
        logic m;
        case (ctrl)
            LH, LHU: m = lane[0];
            LW:      m = (lane != 2'b00);
            default: m = 1'b0;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/data_memory_load_ext.sv
// dmem_load_ext -- load lane selection and sign/zero extension.
// Purely combinational: takes the addressed 32-bit word, the byte lane
// from the address and the funct3 code, and produces the 32-bit load
// result. Unsupported codes return zero.
module dmem_load_ext
    import data_memory_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  Address,
    input  logic [2:0]  DMCtrl,
    output logic [31:0] DataRd
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // Pick the addressed byte and halfword (halfword ignores Address[0]).
    always_comb begin
        case (Address)
            2'b00:   byte_sel = word[7:0];
            2'b01:   byte_sel = word[15:8];
            2'b10:   byte_sel = word[23:16];
            default: byte_sel = word[31:24];
        endcase
        half_sel = Address[1] ? word[31:16] : word[15:0];
    end

    // Size and extend according to the access code.
    always_comb begin
        // NOTE: every path assigns DataRd (default first), so no latch is inferred.
        DataRd = 32'h0000_0000;
        case (DMCtrl)
            LB:      DataRd = {{24{byte_sel[7]}}, byte_sel};
            LH:      DataRd = {{16{half_sel[15]}}, half_sel};
            LW:      DataRd = word;
            LBU:     DataRd = {24'h00_0000, byte_sel};
            LHU:     DataRd = {16'h0000, half_sel};
            default: DataRd = 32'h0000_0000;
        endcase
    end

endmodule

// File: rtl/data_memory.sv
// data_memory -- word-organised data RAM for a single-cycle RISC-V core.
// Combinational reads, byte-enabled synchronous writes, and a hardware
// clear sequence after reset that zeroes one word per cycle while Busy
// is high. Address bits above the array size are ignored, so addresses
// alias modulo 4*DEPTH_WORDS. DEPTH_WORDS must be a power of two, >= 4.
// Optional build macro DATA_MEMORY_MISALIGN_EN: flag misaligned halfword
// and word accesses, suppressing the store and returning zero on a load.
// Without it, Misaligned is 0 and accesses are forced to alignment.
module data_memory
    import data_memory_pkg::*;
#(
    parameter int DEPTH_WORDS = 256
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] Address,
    input  logic [31:0] DataWr,
    input  logic        DMWr,
    input  logic [2:0]  DMCtrl,
    output logic [31:0] DataRd,
    output logic        Busy,
    output logic        Misaligned
);

    localparam int AW = $clog2(DEPTH_WORDS);
    localparam logic [AW-1:0] LAST_WORD = AW'(DEPTH_WORDS - 1);

    dm_state_e     state;
    logic [AW-1:0] clr_cnt;

    logic [31:0]   mem [DEPTH_WORDS];

    logic [AW-1:0] word_idx;
    logic [31:0]   rd_word;
    logic [31:0]   ext_data;
    logic          misaligned_raw;

    logic [AW-1:0] wr_idx;
    logic [31:0]   wr_data;
    logic [3:0]    wr_be;

    // Upper address bits are deliberately dropped; gather them here so the
    // intent is explicit.
    logic          unused_addr_bits;
    assign unused_addr_bits = ^Address[31:AW+2];

    assign word_idx = Address[AW+1:2];
    assign Busy     = (state == CLEAR);

`ifdef DATA_MEMORY_MISALIGN_EN
    assign misaligned_raw = access_misaligned(DMCtrl, Address[1:0]);
    assign Misaligned     = misaligned_raw && !Busy;
`else
    assign misaligned_raw = 1'b0;
    assign Misaligned     = 1'b0;
`endif

    // Clear sequencer: reset restarts from word 0, then one word per cycle.
    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so every
        // flop samples pre-edge values regardless of statement order.
        if (rst) begin
            state   <= CLEAR;
            clr_cnt <= '0;
        end else if (state == CLEAR) begin
            if (clr_cnt == LAST_WORD) begin
                state <= READY;
            end else begin
                clr_cnt <= clr_cnt + AW'(1);
            end
        end
    end

    // Select the single write port's source: clear engine or CPU store.
    always_comb begin
        wr_idx  = word_idx;
        wr_data = 32'h0000_0000;
        wr_be   = 4'b0000;
        if (rst) begin
            wr_be = 4'b0000;
        end else if (Busy) begin
            wr_idx = clr_cnt;
            wr_be  = 4'b1111;
        end else if (DMWr && !misaligned_raw) begin
            wr_data = store_data(DMCtrl, DataWr);
            wr_be   = store_byte_en(DMCtrl, Address[1:0]);
        end
    end

    // Storage with per-byte write enables.
    always_ff @(posedge clk) begin
        // NOTE: the array has no reset branch; it is zeroed by the clear
        // sequence instead, which keeps it mappable onto RAM.
        for (int b = 0; b < 4; b++) begin
            if (wr_be[b]) begin
                mem[wr_idx][8*b +: 8] <= wr_data[8*b +: 8];
            end
        end
    end

    assign rd_word = mem[word_idx];

    dmem_load_ext u_load_ext (
        .word    (rd_word),
        .Address (Address[1:0]),
        .DMCtrl  (DMCtrl),
        .DataRd  (ext_data)
    );

    // Loads read zero while clearing or when flagged misaligned.
    assign DataRd = (Busy || misaligned_raw) ? 32'h0000_0000 : ext_data;

endmodule

// File: doc/data_memory.md
DATA_MEMORY -- requirements
Module: data_memory

Interface
REQ-001 The block SHALL have parameter DEPTH_WORDS, default 256, giving the number of 32-bit words; it SHALL be a power of two and at least 4.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state SHALL update on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: a synchronous, active-high reset.
REQ-004 The block SHALL have port Address, input, 32 bits: the byte address, driven by the ALU result ALURes.
REQ-005 The block SHALL have port DataWr, input, 32 bits: the store data, taken from rs2.
REQ-006 The block SHALL have port DMWr, input, 1 bit: the store request.
REQ-007 The block SHALL have port DMCtrl, input, 3 bits: the access size and sign, encoded as RISC-V funct3.
REQ-008 The block SHALL have port DataRd, output, 32 bits: the load result, sized and extended.
REQ-009 The block SHALL have port Busy, output, 1 bit: high while the memory is being cleared.
REQ-010 The block SHALL have port Misaligned, output, 1 bit: high when the current access is misaligned.

Function
REQ-011 The word index SHALL be Address[log2(DEPTH_WORDS)+1:2]; higher address bits SHALL be ignored, so addresses alias and wrap modulo 4*DEPTH_WORDS.
REQ-012 Reads SHALL be combinational (zero latency, single-cycle datapath), with Address[1:0] selecting the byte or halfword lane.
REQ-013 Load decoding SHALL be:
- 000 LB: sign-extended byte.
- 001 LH: sign-extended half.
- 010 LW: full word.
- 100 LBU: zero-extended byte.
- 101 LHU: zero-extended half.
- 011, 110, 111: DataRd = 0.
REQ-014 A store SHALL occur at the rising edge when DMWr=1, Busy=0 and no suppression per REQ-024 applies.
REQ-015 Store decoding SHALL be:
- 000 SB: writes DataWr[7:0] to the addressed byte lane only.
- 001 SH: writes DataWr[15:0] to lane pair Address[1].
- 010 SW: writes the whole word.
- Any other code with DMWr=1: no write.
REQ-016 On a read and a write to the same address in the same cycle, DataRd SHALL show the old contents before the edge and the new contents after it.
REQ-017 The state machine SHALL have two states, CLEAR and READY; Busy = (state == CLEAR).
REQ-018 In CLEAR, a word counter starting at 0 SHALL write 0 to one word per cycle.
- After word DEPTH_WORDS-1 is written, state -> READY and the counter holds.
- Clearing takes exactly DEPTH_WORDS cycles after rst is released.
REQ-019 While Busy=1, DMWr SHALL be ignored and DataRd SHALL be 0.
REQ-020 Contents and state before the first reset are undefined; the bench SHALL reset first.

Reset
REQ-021 At a rising edge with rst=1, the block SHALL set state = CLEAR and counter = 0; the effect of rst SHALL be visible only after the edge.
REQ-022 From the first edge that samples rst=1: Busy = 1, DataRd = 0, Misaligned = 0; no store occurs while rst=1.
REQ-023 A reset asserted mid-clear or mid-operation SHALL restart the clear from word 0.

Configuration
REQ-024 When macro DATA_MEMORY_MISALIGN_EN is defined:
- Misaligned = 1 for LH/LHU/SH with Address[0]=1, and for LW/SW with Address[1:0] != 00.
- A store flagged this way SHALL be suppressed.
- A load flagged this way SHALL return 0.
- Misaligned SHALL be 0 while Busy=1.
REQ-025 When DATA_MEMORY_MISALIGN_EN is not defined:
- Misaligned is tied to 0.
- Halfword accesses ignore Address[0]; word accesses ignore Address[1:0] (forced alignment).

Structure
REQ-026 Package data_memory_pkg SHALL hold:
- the DMCtrl funct3 constants as enum dmctrl_e (LB, LH, LW, LBU, LHU; SB, SH, SW share codes);
- state enum dm_state_e {CLEAR, READY}.
REQ-027 Load lane selection and extension SHALL be a combinational sub-module dmem_load_ext (inputs: word, Address[1:0], DMCtrl; output: DataRd).
REQ-028 Storage SHALL be a word array with per-byte write enables.

Verification
REQ-029 Clear timing: rst=1 for 2 cycles, then 0 (DEPTH_WORDS=256) -> Busy=1 for exactly 256 cycles after release; then LW from 0x000, 0x3FC and 0x200 returns 0x00000000.
REQ-030 Stores and loads: SW 0x8001F0FF at 0x10, then:
- LB 0x10 -> 0xFFFFFFFF; LBU 0x11 -> 0x000000F0.
- LH 0x12 -> 0xFFFF8001; LHU 0x12 -> 0x00008001; LW 0x10 -> 0x8001F0FF.
REQ-031 Byte merge and aliasing: SW 0x11223344 at 0x20, SB 0xAA at 0x22 -> LW 0x20 = 0x11AA3344; LW at 0x420 aliases and returns 0x11AA3344.
REQ-032 Busy and reset interaction: DMWr=1 SW 0xDEADBEEF at 0x8 during Busy -> no write (LW 0x8 = 0 after clear); rst pulsed at clear cycle 100 -> Busy lasts a further 256 cycles.
REQ-033 Misalignment, with DATA_MEMORY_MISALIGN_EN: SW 0x12345678 at 0x31 -> Misaligned=1, LW 0x30 stays 0; without the macro -> the word is written at 0x30 and Misaligned=0.
REQ-034 Invalid code: DMCtrl=011 with DMWr=1, DataWr=0xFFFFFFFF at 0x40 -> memory is unchanged and DataRd = 0.
